a_skew_feeder: RTL and testbench

A_SKEW_FEEDER -- requirements
Module: a_skew_feeder

---
 rtl/systolic_pkg.sv | 13 +
 rtl/a_skew_lane.sv | 34 +++
 rtl/a_skew_feeder.sv | 116 +++++++++++
 tb/tb_a_skew_feeder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array feeders: default geometry and
// the streaming FSM state encoding.
package systolic_pkg;

   localparam int BITS_AB_DEF = 8;
   localparam int DIM_DEF     = 8;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } feeder_state_e;

endpackage

// File: rtl/a_skew_lane.sv
// One output lane of the A skew feeder: picks the element lane LANE shows at
// step t (row-major or transposed) and zeroes it outside the diagonal window.
module a_skew_lane
   import systolic_pkg::*;
#(
   parameter int BITS_AB = BITS_AB_DEF,
   parameter int DIM     = DIM_DEF,
   parameter int LANE    = 0,
   parameter int TW      = $clog2(2*DIM-1)
) (
   input  logic                      active,
   input  logic [TW-1:0]             t,
   input  logic                      mode,
   input  logic signed [BITS_AB-1:0] row_vals [DIM],
   input  logic signed [BITS_AB-1:0] col_vals [DIM],
   output logic signed [BITS_AB-1:0] elem
);

   localparam int AW = $clog2(DIM);

   logic [TW:0] k;

   // k = t - LANE in one extra bit; t < LANE wraps to a value above DIM, so a
   // single unsigned compare covers both edges of the window.
   assign k = {1'b0, t} - (TW+1)'(LANE);

   always_comb begin
      elem = '0;
      if (active && (k < (TW+1)'(DIM))) begin
         elem = mode ? col_vals[k[AW-1:0]] : row_vals[k[AW-1:0]];
      end
   end

endmodule

// File: rtl/a_skew_feeder.sv
// Holds a DIM x DIM operand matrix and streams it out diagonally skewed, one
// lane per row, so row r lags row r-1 by one step.
module a_skew_feeder
   import systolic_pkg::*;
#(
   parameter int BITS_AB = BITS_AB_DEF,
   parameter int DIM     = DIM_DEF
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic                      WrEn,
   input  logic [$clog2(DIM)-1:0]    Arow,
   input  logic signed [BITS_AB-1:0] Ain [DIM],
   input  logic                      start,
   input  logic                      transpose,
   output logic signed [BITS_AB-1:0] Aout [DIM],
   output logic                      valid,
   output logic                      busy,
   output logic                      done,
   output logic                      wr_drop
);

   localparam int AW = $clog2(DIM);
   localparam int TW = $clog2(2*DIM-1);

   feeder_state_e state, state_nxt;
   logic [TW-1:0] t;
   logic          mode;
   logic          last_step;
   logic          row_ok;
   logic signed [BITS_AB-1:0] mem      [DIM][DIM];
   logic signed [BITS_AB-1:0] col_view [DIM][DIM];

   assign last_step = (t == TW'(2*DIM-2));
   assign row_ok    = ({1'b0, Arow} < (AW+1)'(DIM));
   assign busy      = (state == STREAM);
   assign valid     = busy & en;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = STREAM;
         STREAM:  if (en && last_step) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Mode is captured only on an accepted start, so it stays fixed per stream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t    <= '0;
         mode <= 1'b0;
      end else if (state == IDLE) begin
         if (start) begin
            t    <= '0;
            mode <= transpose;
         end
      end else if (en) begin
         t <= last_step ? '0 : t + TW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done    <= 1'b0;
         wr_drop <= 1'b0;
      end else begin
         done    <= busy && en && last_step;
         wr_drop <= busy && WrEn;
      end
   end

   // Writes land only in IDLE, so a write paired with start is seen from t=0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
               mem[r][c] <= '0;
            end
         end
      end else if ((state == IDLE) && WrEn && row_ok) begin
         for (int c = 0; c < DIM; c++) begin
            mem[Arow][c] <= Ain[c];
         end
      end
   end

   for (genvar r = 0; r < DIM; r++) begin : g_col
      for (genvar c = 0; c < DIM; c++) begin : g_elem
         assign col_view[r][c] = mem[c][r];
      end
   end

   for (genvar r = 0; r < DIM; r++) begin : g_lane
      a_skew_lane #(
         .BITS_AB (BITS_AB),
         .DIM     (DIM),
         .LANE    (r),
         .TW      (TW)
      ) u_lane (
         .active   (busy),
         .t        (t),
         .mode     (mode),
         .row_vals (mem[r]),
         .col_vals (col_view[r]),
         .elem     (Aout[r])
      );
   end

endmodule

// File: tb/tb_a_skew_feeder.sv
// Self-checking bench for a_skew_feeder (DIM=4, BITS_AB=8): directed streams
// plus random traffic, all compared against a step-level matrix model.
module tb_a_skew_feeder;

   localparam int DIM  = 4;
   localparam int BITS = 8;
   localparam int LAST = 2*DIM-2;

   logic                   clk;
   logic                   rst_n;
   logic                   en;
   logic                   WrEn;
   logic [1:0]             Arow;
   logic signed [BITS-1:0] Ain [DIM];
   logic                   start;
   logic                   transpose;
   logic signed [BITS-1:0] Aout [DIM];
   logic                   valid;
   logic                   busy;
   logic                   done;
   logic                   wr_drop;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] m_mem [DIM][DIM];
   bit         m_busy;
   int         m_t;
   bit         m_mode;
   bit         m_done;
   bit         m_drop;
   int         obs_valid;

   a_skew_feeder #(.BITS_AB(BITS), .DIM(DIM)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .WrEn      (WrEn),
      .Arow      (Arow),
      .Ain       (Ain),
      .start     (start),
      .transpose (transpose),
      .Aout      (Aout),
      .valid     (valid),
      .busy      (busy),
      .done      (done),
      .wr_drop   (wr_drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Lane r at step t shows element k = t - r of its row (or column when transposed).
   function automatic logic [7:0] expLane(input int r);
      int k;
      k = m_t - r;
      if (!m_busy || k < 0 || k >= DIM) return 8'h00;
      return m_mode ? m_mem[k][r] : m_mem[r][k];
   endfunction

   task automatic modelReset();
      for (int r = 0; r < DIM; r++)
         for (int c = 0; c < DIM; c++)
            m_mem[r][c] = 8'h00;
      m_busy = 0; m_t = 0; m_mode = 0; m_done = 0; m_drop = 0; obs_valid = 0;
   endtask

   task automatic modelUpdate();
      bit nd, ndr;
      nd  = m_busy && en && (m_t == LAST);
      ndr = m_busy && WrEn;
      if (!m_busy) begin
         if (WrEn && int'(Arow) < DIM)
            for (int c = 0; c < DIM; c++) m_mem[Arow][c] = Ain[c];
         if (start) begin
            m_busy = 1; m_t = 0; m_mode = transpose;
         end
      end else if (en) begin
         if (m_t == LAST) m_busy = 0;
         else m_t++;
      end
      m_done = nd;
      m_drop = ndr;
   endtask

   task automatic checkCycle();
      for (int r = 0; r < DIM; r++)
         checkOutput($sformatf("aout%0d", r), {24'b0, Aout[r]}, {24'b0, expLane(r)});
      checkOutput("valid",   32'(valid),   32'(m_busy && en));
      checkOutput("busy",    32'(busy),    32'(m_busy));
      checkOutput("done",    32'(done),    32'(m_done));
      checkOutput("wr_drop", 32'(wr_drop), 32'(m_drop));
      if (m_done) begin
         checkOutput("valid_count", 32'(obs_valid), 32'(2*DIM-1));
         obs_valid = 0;
      end
      if (valid) obs_valid++;
   endtask

   task automatic applyStimulus(input bit e, input bit wr, input logic [1:0] row, input bit st, input bit tr);
      en = e; WrEn = wr; Arow = row; start = st; transpose = tr;
      #1;
      checkCycle();
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst_n) modelReset();
      else modelUpdate();
      #1;
   endtask

   task automatic checkAout(input string tag, input logic [7:0] e0, e1, e2, e3);
      checkOutput({tag, "_0"}, {24'b0, Aout[0]}, {24'b0, e0});
      checkOutput({tag, "_1"}, {24'b0, Aout[1]}, {24'b0, e1});
      checkOutput({tag, "_2"}, {24'b0, Aout[2]}, {24'b0, e2});
      checkOutput({tag, "_3"}, {24'b0, Aout[3]}, {24'b0, e3});
   endtask

   task automatic loadMatrix();
      for (int r = 0; r < DIM; r++) begin
         for (int c = 0; c < DIM; c++) Ain[c] = 8'(16*r + c);
         applyStimulus(1, 1, 2'(r), 0, 0);
         tick();
      end
   endtask

   // Steps through the active stream; literal checks assume the 16r+c matrix.
   task automatic streamBody(input int hold_at, input int wr_at, input bit literal, input int stop_at);
      int holds = 0;
      int guard = 0;
      bit e;
      bit wr;
      while (m_busy && m_t != stop_at && guard < 40) begin
         guard++;
         e  = !(m_t == hold_at && holds < 3);
         if (!e) holds++;
         wr = (m_t == wr_at) && e;
         if (wr) for (int c = 0; c < DIM; c++) Ain[c] = 8'h5A;
         applyStimulus(e, wr, 2'd1, 0, 0);
         if (literal && !m_mode && m_t == 0) checkAout("t0_m0", 8'h00, 8'h00, 8'h00, 8'h00);
         if (literal && !m_mode && m_t == 3) checkAout("t3_m0", 8'h03, 8'h12, 8'h21, 8'h30);
         if (literal && !m_mode && m_t == 6) checkAout("t6_m0", 8'h00, 8'h00, 8'h00, 8'h33);
         if (literal &&  m_mode && m_t == 3) checkAout("t3_m1", 8'h30, 8'h21, 8'h12, 8'h03);
         tick();
      end
      if (guard >= 40) checkOutput("stream_bound", 32'(busy), 32'd0);
   endtask

   task automatic doneCycle(input bit st, input bit tr);
      applyStimulus(1, 0, 2'd0, st, tr);
      checkOutput("done_pulse", 32'(done), 32'd1);
      tick();
   endtask

   initial begin
      rst_n = 1'b0; en = 0; WrEn = 0; Arow = 0; start = 0; transpose = 0;
      for (int c = 0; c < DIM; c++) Ain[c] = '0;
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      applyStimulus(1, 0, 0, 0, 0);
      rst_n = 1'b1;
      tick();

      loadMatrix();
      applyStimulus(1, 0, 0, 1, 0);
      tick();
      streamBody(-1, -1, 1, -1);
      doneCycle(1, 1);
      streamBody(2, 4, 1, -1);
      doneCycle(1, 0);
      streamBody(-1, -1, 1, -1);
      doneCycle(0, 0);

      for (int c = 0; c < DIM; c++) Ain[c] = 8'h7F;
      applyStimulus(1, 1, 2'd0, 1, 0);
      tick();
      applyStimulus(1, 0, 2'd0, 0, 0);
      checkOutput("wr_start_t0", {24'b0, Aout[0]}, 32'h7F);
      tick();
      streamBody(-1, -1, 0, -1);
      doneCycle(0, 0);

      applyStimulus(1, 0, 0, 1, 0);
      tick();
      streamBody(-1, -1, 0, 3);
      rst_n = 1'b0;
      #1;
      modelReset();
      checkOutput("rst_busy",  32'(busy),  32'd0);
      checkOutput("rst_valid", 32'(valid), 32'd0);
      checkAout("rst_aout", 8'h00, 8'h00, 8'h00, 8'h00);
      tick();
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("rst_no_done", 32'(done), 32'd0);
      rst_n = 1'b1;
      tick();
      applyStimulus(1, 0, 0, 1, 0);
      tick();
      streamBody(-1, -1, 0, 3);
      checkAout("post_rst_t3", 8'h00, 8'h00, 8'h00, 8'h00);
      streamBody(-1, -1, 0, -1);
      doneCycle(0, 0);

      for (int i = 0; i < 400; i++) begin
         for (int c = 0; c < DIM; c++) Ain[c] = 8'($urandom);
         applyStimulus($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 3,
                       2'($urandom_range(0, 3)), $urandom_range(0, 9) < 2, 1'($urandom));
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
